// File: rtl/line_stream_feeder.sv
// Frame source: streams frame-memory lines to the image core, preload lines back to back,
// remaining lines and trailing zero pad lines on core requests, with a 2-entry output FIFO.
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | waiting for start
// PRELOAD  | issuing the first PRELOAD_LINES lines unconditionally
// WAIT_REQ | image line pending, waiting for a captured request
// LINE     | issuing one image line
// PAD_WAIT | pad line pending, waiting for a captured request
// PAD      | issuing one zero line
// DONE     | all slots issued, draining the output FIFO
module line_stream_feeder #(
    parameter int IMG_WIDTH     = 512,
    parameter int IMG_HEIGHT    = 512,
    parameter int PIXEL_W       = 8,
    parameter int PRELOAD_LINES = 4,
    parameter int PAD_LINES     = 2,
    parameter int ADDR_W        = 18
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [PIXEL_W-1:0] rd_data,
    input  logic               line_req,
    output logic [PIXEL_W-1:0] outData,
    output logic               outDataValid,
    input  logic               outDataReady,
    output logic               busy,
    output logic               done,
    output logic               req_overflow
);

    localparam int COL_W       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int TOTAL_LINES = IMG_HEIGHT + PAD_LINES;
    localparam int LINE_W      = $clog2(TOTAL_LINES + 1);

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [LINE_W-1:0] PRE_END  = LINE_W'(PRELOAD_LINES);
    localparam logic [LINE_W-1:0] IMG_END  = LINE_W'(IMG_HEIGHT);
    localparam logic [LINE_W-1:0] PAD_END  = LINE_W'(TOTAL_LINES);

    typedef enum logic [2:0] {
        IDLE, PRELOAD, WAIT_REQ, LINE, PAD_WAIT, PAD, DONE
    } state_t;

    state_t state, nextState, postImage;

    logic [ADDR_W-1:0]  baseQ, addrOff;
    logic [COL_W-1:0]   colLeft;
    logic [LINE_W-1:0]  lineCount, lineNext;
    logic               reqQ, reqQQ, reqEdge;
    logic [1:0]         pending;
    logic               consume;

    logic [PIXEL_W-1:0] fifoMem [2];
    logic               wrPtr, rdPtr;
    logic [1:0]         fifoCount;
    logic               inflight, inflightZero;
    logic [PIXEL_W-1:0] arriveData;
    logic               pop, push, popFifo;
    logic [2:0]         occAfterPop;
    logic               issueState, issue, lineEnd, drained, startAccept;

    assign startAccept = (state == IDLE) && start;
    assign pop         = outDataValid && outDataReady;
    assign occAfterPop = 3'(fifoCount) + 3'(inflight) - 3'(pop);
    assign issueState  = (state == PRELOAD) || (state == LINE) || (state == PAD);
    assign issue       = issueState && (occAfterPop < 3'd2);
    assign lineEnd     = issue && (colLeft == '0);
    assign lineNext    = lineCount + 1'b1;
    assign reqEdge     = reqQ && !reqQQ;
    assign consume     = ((state == WAIT_REQ) || (state == PAD_WAIT)) && (pending != 2'd0);
    assign drained     = (fifoCount == 2'd0) && !inflight;
    assign arriveData  = inflightZero ? '0 : rd_data;
    // An empty FIFO passes the arriving pixel straight through; a stalled one is captured.
    assign push        = inflight && !((fifoCount == 2'd0) && pop);
    assign popFifo     = pop && (fifoCount != 2'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nextState;
    end

    always_comb begin
        nextState = state;
        postImage = (PAD_LINES == 0) ? DONE : PAD_WAIT;
        case (state)
            IDLE:     if (start) nextState = (PRELOAD_LINES == 0) ? WAIT_REQ : PRELOAD;
            PRELOAD:  if (lineEnd && (lineNext == PRE_END))
                          nextState = (lineNext == IMG_END) ? postImage : WAIT_REQ;
            WAIT_REQ: if (pending != 2'd0) nextState = LINE;
            LINE:     if (lineEnd) nextState = (lineNext == IMG_END) ? postImage : WAIT_REQ;
            PAD_WAIT: if (pending != 2'd0) nextState = PAD;
            PAD:      if (lineEnd) nextState = (lineNext == PAD_END) ? DONE : PAD_WAIT;
            DONE:     if (drained) nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    always_comb begin
        rd_en        = issue && (state != PAD);
        rd_addr      = rd_en ? (baseQ + addrOff) : '0;
        done         = (state == DONE) && drained;
        busy         = (state != IDLE) && !done;
        outDataValid = (fifoCount != 2'd0) || inflight;
        outData      = '0;
        if (fifoCount != 2'd0) outData = fifoMem[rdPtr];
        else if (inflight)     outData = arriveData;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baseQ        <= '0;
            addrOff      <= '0;
            colLeft      <= '0;
            lineCount    <= '0;
            reqQ         <= 1'b0;
            reqQQ        <= 1'b0;
            pending      <= 2'd0;
            req_overflow <= 1'b0;
        end else begin
            reqQ  <= line_req;
            reqQQ <= reqQ;
            if (startAccept) begin
                baseQ        <= base_addr;
                addrOff      <= '0;
                colLeft      <= COL_LAST;
                lineCount    <= '0;
                req_overflow <= 1'b0;
            end else if (issue) begin
                if (state != PAD) addrOff <= addrOff + 1'b1;
                if (colLeft == '0) begin
                    colLeft   <= COL_LAST;
                    lineCount <= lineNext;
                end else begin
                    colLeft <= colLeft - 1'b1;
                end
            end
            if (state == IDLE) begin
                pending <= 2'd0;
            end else begin
                case ({reqEdge, consume})
                    2'b10: begin
                        if (pending == 2'd3) req_overflow <= 1'b1;
                        else                 pending      <= pending + 2'd1;
                    end
                    2'b01:   pending <= pending - 2'd1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifoMem[0]   <= '0;
            fifoMem[1]   <= '0;
            wrPtr        <= 1'b0;
            rdPtr        <= 1'b0;
            fifoCount    <= 2'd0;
            inflight     <= 1'b0;
            inflightZero <= 1'b0;
        end else begin
            inflight     <= issue;
            inflightZero <= issue && (state == PAD);
            if (push) begin
                fifoMem[wrPtr] <= arriveData;
                wrPtr          <= ~wrPtr;
            end
            if (popFifo) rdPtr <= ~rdPtr;
            case ({push, popFifo})
                2'b10:   fifoCount <= fifoCount + 2'd1;
                2'b01:   fifoCount <= fifoCount - 2'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_stream_feeder.sv
// Bench for line_stream_feeder: 8x6 frame, 4 preload lines, 2 pad lines, scoreboarded output stream.
module tb_line_stream_feeder;

    localparam int W = 8, H = 6, PRE = 4, PADL = 2, AW = 18, PW = 8;

    logic          clk = 1'b0;
    logic          reset_n, start, rd_en, line_req, outDataValid, outDataReady;
    logic          busy, done, req_overflow;
    logic [AW-1:0] base_addr, rd_addr;
    logic [PW-1:0] rd_data = '0;
    logic [PW-1:0] outData;

    always #5 clk = ~clk;

    line_stream_feeder #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_W(PW),
        .PRELOAD_LINES(PRE), .PAD_LINES(PADL), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .line_req(line_req),
        .outData(outData), .outDataValid(outDataValid), .outDataReady(outDataReady),
        .busy(busy), .done(done), .req_overflow(req_overflow)
    );

    // Frame memory contents: low address byte, folded with high address bits.
    function automatic logic [PW-1:0] memVal(input logic [AW-1:0] a);
        return a[7:0] ^ {a[17:12], 2'b00};
    endfunction

    always @(posedge clk) if (rd_en) rd_data <= memVal(rd_addr);

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic [PW-1:0] expQ[$];
    int   beats = 0, cyc = 0, lastBeatCyc = 0, doneCount = 0, doneCyc = 0;
    logic busyAtDone = 1'b0;
    logic stalled = 1'b0;
    logic [PW-1:0] heldData = '0;
    bit   toggleMode = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 32'(outDataValid), 32'd1);
                check("stall_data", 32'(outData), 32'(heldData));
            end
            if (outDataValid && outDataReady) begin
                beats++;
                lastBeatCyc = cyc;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got data %0h, expected no beat", outData);
                end else begin
                    check("beat", 32'(outData), 32'(expQ.pop_front()));
                end
            end
            stalled  = outDataValid && !outDataReady;
            heldData = outData;
            if (done) begin
                doneCount++;
                doneCyc    = cyc;
                busyAtDone = busy;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggleMode) outDataReady = ~outDataReady;
    endtask

    task automatic pushLine(input logic [AW-1:0] base, input int firstIdx, input bit zero);
        for (int i = 0; i < W; i++)
            expQ.push_back(zero ? '0 : memVal(AW'(base + AW'(firstIdx + i))));
    endtask

    task automatic pulseReq();
        line_req = 1'b1;
        tick();
        tick();
        line_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic waitBeats(input int target, input string name);
        int n = 0;
        while (beats < target && n < 400) begin
            tick();
            n++;
        end
        check(name, 32'(beats), 32'(target));
    endtask

    typedef struct {
        string name;
        int    edges;
        bit    toggle;
        int    nBeats;
        int    firstIdx;
        bit    zero;
    } phase_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        phase_t tbl[3];
        int     frameStart, b, c2cyc;
        logic [AW-1:0] baseC;

        tbl[0] = '{"line4", 1, 1'b1, 8,  32, 1'b0};
        tbl[1] = '{"line5", 1, 1'b0, 8,  40, 1'b0};
        tbl[2] = '{"pads",  2, 1'b0, 16, 0,  1'b1};

        reset_n = 1'b1; start = 1'b0; line_req = 1'b0; outDataReady = 1'b1; base_addr = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", 32'({rd_en, outDataValid, busy, done, req_overflow}), 32'd0);
        check("reset_addr", 32'(rd_addr), 32'd0);
        check("reset_data", 32'(outData), 32'd0);
        reset_n = 1'b1;
        tick();

        // Frame interrupted by reset
        for (int i = 0; i < PRE; i++) pushLine('0, i * W, 1'b0);
        base_addr = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        #2 reset_n = 1'b0;
        #1;
        check("midrst_ctrl", 32'({rd_en, outDataValid, busy, done, req_overflow}), 32'd0);
        check("midrst_addr", 32'(rd_addr), 32'd0);
        check("midrst_data", 32'(outData), 32'd0);
        expQ.delete();
        tick();
        reset_n = 1'b1;
        tick();

        // Full frame at base 0
        doneCount  = 0;
        frameStart = beats;
        for (int i = 0; i < PRE; i++) pushLine('0, i * W, 1'b0);
        base_addr = '0;
        start = 1'b1;
        #1;
        check("lat_c0_rd_en", 32'(rd_en), 32'd0);
        check("lat_c0_busy", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        check("lat_c1_rd_en", 32'(rd_en), 32'd1);
        check("lat_c1_addr", 32'(rd_addr), 32'd0);
        check("lat_c1_valid", 32'(outDataValid), 32'd0);
        check("lat_c1_busy", 32'(busy), 32'd1);
        tick();
        c2cyc = cyc;
        check("lat_c2_valid", 32'(outDataValid), 32'd1);
        check("lat_c2_data", 32'(outData), 32'(memVal('0)));
        waitBeats(frameStart + PRE * W, "preload_beats");
        check("preload_span", 32'(lastBeatCyc - c2cyc), 32'(PRE * W - 1));
        b = beats;
        repeat (20) tick();
        check("preload_idle_beats", 32'(beats), 32'(b));
        check("preload_idle_busy", 32'(busy), 32'd1);

        for (int p = 0; p < 3; p++) begin
            b = beats;
            for (int l = 0; l < tbl[p].nBeats / W; l++)
                pushLine('0, tbl[p].firstIdx + l * W, tbl[p].zero);
            toggleMode = tbl[p].toggle;
            for (int e = 0; e < tbl[p].edges; e++) pulseReq();
            waitBeats(b + tbl[p].nBeats, tbl[p].name);
            toggleMode   = 1'b0;
            outDataReady = 1'b1;
            if (p < 2) begin
                b = beats;
                repeat (20) tick();
                check({tbl[p].name, "_idle_beats"}, 32'(beats), 32'(b));
                check({tbl[p].name, "_idle_busy"}, 32'(busy), 32'd1);
            end
        end
        repeat (5) tick();
        check("done_count", 32'(doneCount), 32'd1);
        check("done_after_last", 32'(doneCyc), 32'(lastBeatCyc + 1));
        check("busy_at_done", 32'(busyAtDone), 32'd0);
        check("frame_beats", 32'(beats - frameStart), 32'((H + PADL) * W));
        check("busy_after", 32'(busy), 32'd0);
        check("overflow_clear", 32'(req_overflow), 32'd0);
        check("queue_empty", 32'(expQ.size()), 32'd0);

        // Frame near the top of the address space, requests queued during preload
        baseC      = AW'(262144 - 20);
        doneCount  = 0;
        frameStart = beats;
        for (int i = 0; i < H; i++) pushLine(baseC, i * W, 1'b0);
        pushLine(baseC, 0, 1'b1);
        base_addr = baseC;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) pulseReq();
        check("ovf_set", 32'(req_overflow), 32'd1);
        waitBeats(frameStart + (H + 1) * W, "queued_beats");
        b = beats;
        repeat (20) tick();
        check("queued_idle_beats", 32'(beats), 32'(b));
        check("queued_idle_busy", 32'(busy), 32'd1);
        pushLine(baseC, 0, 1'b1);
        pulseReq();
        waitBeats(frameStart + (H + PADL) * W, "last_pad");
        repeat (5) tick();
        check("c_done_count", 32'(doneCount), 32'd1);
        check("c_ovf_sticky", 32'(req_overflow), 32'd1);
        check("c_busy_after", 32'(busy), 32'd0);

        // Next start clears the sticky overflow flag
        for (int i = 0; i < PRE; i++) pushLine('0, i * W, 1'b0);
        base_addr = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("ovf_cleared", 32'(req_overflow), 32'd0);
        repeat (6) tick();
        #2 reset_n = 1'b0;
        expQ.delete();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
